tangle_soc_top: RTL and testbench

- Minimal 16-bit SoC: accumulator CPU plus single-port word-addressed RAM holding both program and data.
- CPU flags ZF/SF/CF drive three active-low board LEDs for visual debug.
- Top-level block of the FPGA build; no other I/O.

---
 rtl/tangle_soc_top.sv | 209 ++++++++++++++++++++
 tb/tb_tangle_soc_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tangle_soc_top.sv
// tangle_soc_top: 16-bit accumulator CPU sharing one word-addressed RAM for code and data.
// Flags ZF/SF/CF drive active-low LEDs. RAM starts zero-filled.
module tangle_soc_top #(
    parameter int    RAM_SIZE_LOG  = 8,
    parameter string MEM_INIT_FILE = "program.hex"
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic led1,
    output logic led2,
    output logic led3
);

    localparam int RAM_DEPTH = 1 << RAM_SIZE_LOG;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_JS  = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] acc_q, acc_d;
    logic        zf_q, zf_d;
    logic        sf_q, sf_d;
    logic        cf_q, cf_d;
    logic [1:0]  state_q, state_d;

    logic [15:0] mem_q [RAM_DEPTH] = '{default: 16'h0000};
    localparam string unused_mem_init_file = MEM_INIT_FILE;

    logic [15:0]             mem_rdata_q;
    logic [15:0]             mem_addr;
    logic [15:0]             mem_wdata;
    logic                    mem_we;
    logic [RAM_SIZE_LOG-1:0] mem_index;

    logic        halted;
    logic [3:0]  op;
    logic [15:0] operand_addr;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [15:0] result;
    logic        set_zs;

    assign halted       = (state_q == S_HALT);
    assign op           = ir_q[15:12];
    assign operand_addr = {4'h0, ir_q[11:0]};
    assign sum          = {1'b0, acc_q} + {1'b0, mem_rdata_q};
    assign diff         = {1'b0, acc_q} - {1'b0, mem_rdata_q};

    // Upper address bits simply alias onto the smaller RAM.
    assign mem_index = mem_addr[RAM_SIZE_LOG-1:0];
    generate
        if (RAM_SIZE_LOG < 16) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_addr[15:RAM_SIZE_LOG];
        end
    endgenerate

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        acc_d     = acc_q;
        zf_d      = zf_q;
        sf_d      = sf_q;
        cf_d      = cf_q;
        state_d   = state_q;
        mem_addr  = pc_q;
        mem_wdata = acc_q;
        mem_we    = 1'b0;
        result    = acc_q;
        set_zs    = 1'b0;

        if (!halted) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_addr = pc_q;
                    state_d  = S_DECODE;
                end
                S_DECODE: begin
                    // IR is not loaded yet, so the operand address comes straight off the read port.
                    ir_d     = mem_rdata_q;
                    pc_d     = pc_q + 16'd1;
                    mem_addr = {4'h0, mem_rdata_q[11:0]};
                    state_d  = S_EXEC;
                end
                S_EXEC: begin
                    mem_addr = operand_addr;
                    state_d  = S_FETCH;
                    unique case (op)
                        OP_NOP: begin end
                        OP_LDA: begin
                            result = mem_rdata_q;
                            acc_d  = result;
                            set_zs = 1'b1;
                        end
                        OP_STA: mem_we = 1'b1;
                        OP_ADD: begin
                            result = sum[15:0];
                            acc_d  = result;
                            cf_d   = sum[16];
                            set_zs = 1'b1;
                        end
                        OP_SUB: begin
                            result = diff[15:0];
                            acc_d  = result;
                            cf_d   = diff[16];
                            set_zs = 1'b1;
                        end
                        OP_AND: begin
                            result = acc_q & mem_rdata_q;
                            acc_d  = result;
                            cf_d   = 1'b0;
                            set_zs = 1'b1;
                        end
                        OP_OR: begin
                            result = acc_q | mem_rdata_q;
                            acc_d  = result;
                            cf_d   = 1'b0;
                            set_zs = 1'b1;
                        end
                        OP_XOR: begin
                            result = acc_q ^ mem_rdata_q;
                            acc_d  = result;
                            cf_d   = 1'b0;
                            set_zs = 1'b1;
                        end
                        OP_LDI: begin
                            result = operand_addr;
                            acc_d  = result;
                            set_zs = 1'b1;
                        end
                        OP_JMP: pc_d = operand_addr;
                        OP_JZ:  if (zf_q)  pc_d = operand_addr;
                        OP_JNZ: if (!zf_q) pc_d = operand_addr;
                        OP_JC:  if (cf_q)  pc_d = operand_addr;
                        OP_JS:  if (sf_q)  pc_d = operand_addr;
                        OP_CMP: begin
                            result = diff[15:0];
                            cf_d   = diff[16];
                            set_zs = 1'b1;
                        end
                        OP_HLT: state_d = S_HALT;
                    endcase
                end
                default: state_d = S_HALT;
            endcase
        end

        if (set_zs) begin
            zf_d = (result == 16'h0000);
            sf_d = result[15];
        end

        // A store racing an asserted reset must never reach the RAM.
        mem_we = mem_we & rst_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= 16'h0000;
            ir_q    <= 16'h0000;
            acc_q   <= 16'h0000;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            cf_q    <= 1'b0;
            state_q <= S_FETCH;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            cf_q    <= cf_d;
            state_q <= state_d;
        end
    end

    // Block RAM: no reset, registered read so data lands one cycle after the address.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_index] <= mem_wdata;
        end
        mem_rdata_q <= mem_q[mem_index];
    end

    assign led1 = ~zf_q;
    assign led2 = ~sf_q;
    assign led3 = ~cf_q;

endmodule

// File: tb/tb_tangle_soc_top.sv
// Bench for tangle_soc_top: directed program table, async-reset sequence, and random
// programs checked instruction by instruction against an ISA-level reference model.
`timescale 1ns/1ps
module tb_tangle_soc_top;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic led1, led2, led3;

    tangle_soc_top #(.RAM_SIZE_LOG(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .led1  (led1),
        .led2  (led2),
        .led3  (led3)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] img [256];

    // ISA-level reference model state
    logic [15:0] m_mem [256];
    logic [15:0] m_pc, m_acc;
    logic        m_zf, m_sf, m_cf, m_halt;

    typedef struct {
        string             name;
        logic [15:0][15:0] prog;
        logic [15:0]       d20, d21, d23;
        int                exp_cycles;
        logic [15:0]       exp_pc, exp_acc, exp_m22;
        logic [2:0]        exp_leds;
        int                exp_we;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] leds_now();
        return {13'h0, led1, led2, led3};
    endfunction

    task automatic set_vec(input int i, input string nm,
                           input logic [15:0] d20, input logic [15:0] d21, input logic [15:0] d23,
                           input int cyc, input logic [15:0] pc, input logic [15:0] acc,
                           input logic [15:0] m22, input logic [2:0] leds, input int we);
        vt[i].name       = nm;
        vt[i].d20        = d20;
        vt[i].d21        = d21;
        vt[i].d23        = d23;
        vt[i].exp_cycles = cyc;
        vt[i].exp_pc     = pc;
        vt[i].exp_acc    = acc;
        vt[i].exp_m22    = m22;
        vt[i].exp_leds   = leds;
        vt[i].exp_we     = we;
    endtask

    // Hold reset, load img into the DUT RAM and the model, release on a falling edge.
    task automatic start_run();
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++) begin
            m_mem[i]     = img[i];
            dut.mem_q[i] = img[i];
        end
        m_pc = 16'h0; m_acc = 16'h0;
        m_zf = 1'b0; m_sf = 1'b0; m_cf = 1'b0; m_halt = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic set_zs(input logic [15:0] r);
        m_zf = (r == 16'h0);
        m_sf = r[15];
    endtask

    // One whole instruction, straight from the instruction-set rules.
    task automatic model_step();
        logic [15:0] ir, m, target;
        logic [3:0]  op;
        int unsigned wide;
        if (m_halt) return;
        ir     = m_mem[m_pc[7:0]];
        m_pc   = m_pc + 16'd1;
        op     = ir[15:12];
        target = {4'h0, ir[11:0]};
        m      = m_mem[target[7:0]];
        case (op)
            4'h1: begin m_acc = m; set_zs(m_acc); end
            4'h2: m_mem[target[7:0]] = m_acc;
            4'h3: begin
                wide  = 32'(m_acc) + 32'(m);
                m_cf  = (wide > 32'd65535);
                m_acc = 16'(wide);
                set_zs(m_acc);
            end
            4'h4: begin m_cf = (m_acc < m); m_acc = m_acc - m; set_zs(m_acc); end
            4'h5: begin m_acc = m_acc & m; m_cf = 1'b0; set_zs(m_acc); end
            4'h6: begin m_acc = m_acc | m; m_cf = 1'b0; set_zs(m_acc); end
            4'h7: begin m_acc = m_acc ^ m; m_cf = 1'b0; set_zs(m_acc); end
            4'h8: begin m_acc = target; set_zs(m_acc); end
            4'h9: m_pc = target;
            4'hA: if (m_zf)  m_pc = target;
            4'hB: if (!m_zf) m_pc = target;
            4'hC: if (m_cf)  m_pc = target;
            4'hD: if (m_sf)  m_pc = target;
            4'hE: begin m_cf = (m_acc < m); set_zs(m_acc - m); end
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, we_cnt, diffs;
        logic [3:0] rop;

        // ---------------- directed program table ----------------
        for (int i = 0; i < NV; i++) vt[i].prog = '0;
        vt[0].prog[0] = 16'h8005; vt[0].prog[1] = 16'h3020; vt[0].prog[2] = 16'hF000;
        set_vec(0, "add_carry", 16'hFFFB, 16'h0, 16'h0, 9, 16'd3, 16'h0000, 16'h5555, 3'b010, 0);
        vt[1].prog[0] = 16'h8003; vt[1].prog[1] = 16'h4021; vt[1].prog[2] = 16'h2022; vt[1].prog[3] = 16'hF000;
        set_vec(1, "sub_sta", 16'h0, 16'h0004, 16'h0, 12, 16'd4, 16'hFFFF, 16'hFFFF, 3'b100, 1);
        vt[2].prog[0] = 16'h8003; vt[2].prog[1] = 16'h4023; vt[2].prog[2] = 16'hB001; vt[2].prog[3] = 16'hF000;
        set_vec(2, "loop", 16'h0, 16'h0, 16'h0001, 24, 16'd4, 16'h0000, 16'h5555, 3'b011, 0);
        vt[3].prog[0] = 16'h8010; vt[3].prog[1] = 16'hE020; vt[3].prog[2] = 16'hC007; vt[3].prog[3] = 16'hA005;
        vt[3].prog[4] = 16'h8FFF; vt[3].prog[5] = 16'hF000; vt[3].prog[7] = 16'h8BAD;
        set_vec(3, "cmp_jz_jc", 16'h0010, 16'h0, 16'h0, 15, 16'd6, 16'h0010, 16'h5555, 3'b011, 0);
        vt[4].prog[0] = 16'h8001; vt[4].prog[1] = 16'h4023; vt[4].prog[2] = 16'h6020; vt[4].prog[3] = 16'h5021;
        vt[4].prog[4] = 16'h7021; vt[4].prog[5] = 16'h2022; vt[4].prog[6] = 16'hF000;
        set_vec(4, "logic_ops", 16'h0F0F, 16'hFF00, 16'h0002, 21, 16'd7, 16'h0000, 16'h0000, 3'b011, 1);
        vt[5].prog[0] = 16'h8000; vt[5].prog[1] = 16'h4023; vt[5].prog[2] = 16'hD006; vt[5].prog[3] = 16'hF000;
        vt[5].prog[4] = 16'hF000; vt[5].prog[5] = 16'hF000; vt[5].prog[6] = 16'h9009; vt[5].prog[7] = 16'hF000;
        vt[5].prog[8] = 16'hF000; vt[5].prog[9] = 16'h1020; vt[5].prog[10] = 16'hF000;
        set_vec(5, "js_jmp_lda", 16'h0F0F, 16'h0, 16'h0002, 18, 16'd11, 16'h0F0F, 16'h5555, 3'b110, 0);

        // ---------------- reset and async abort of a store ----------------
        for (int i = 0; i < 256; i++) img[i] = 16'h0;
        img[0] = 16'h8000; img[1] = 16'h2030; img[2] = 16'hF000; img[8'h30] = 16'h1234;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_pc", dut.pc_q, 16'h0);
        chk("reset_acc", dut.acc_q, 16'h0);
        chk("reset_leds", leds_now(), 16'h0007);
        start_run();
        @(posedge clk_i); #1;
        chk("fetch0_pc", dut.pc_q, 16'h0);
        @(posedge clk_i); #1;
        chk("decode0_pc", dut.pc_q, 16'h1);
        @(posedge clk_i); #1;
        chk("ldi0_leds", leds_now(), 16'h0003);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("sta_exec_we", 16'(dut.mem_we), 16'h1);
        rst_i = 1'b0;
        #1;
        chk("async_leds", leds_now(), 16'h0007);
        chk("async_pc", dut.pc_q, 16'h0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("aborted_store", dut.mem_q[8'h30], 16'h1234);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (9) @(posedge clk_i);
        #1;
        chk("store_after_reset", dut.mem_q[8'h30], 16'h0000);
        $display("reset sequence: async abort and restart checked");

        // ---------------- apply the table ----------------
        for (int t = 0; t < NV; t++) begin
            for (int i = 0; i < 256; i++) img[i] = 16'h0;
            for (int i = 0; i < 16; i++) img[i] = vt[t].prog[i];
            img[8'h20] = vt[t].d20;
            img[8'h21] = vt[t].d21;
            img[8'h22] = 16'h5555;
            img[8'h23] = vt[t].d23;
            start_run();
            cyc = 0;
            we_cnt = 0;
            while (!dut.halted && cyc < 400) begin
                if (dut.mem_we) we_cnt++;
                @(posedge clk_i); #1;
                cyc++;
            end
            chk({vt[t].name, "_cycles"}, 16'(cyc), 16'(vt[t].exp_cycles));
            repeat (6) @(posedge clk_i);
            #1;
            chk({vt[t].name, "_pc_frozen"}, dut.pc_q, vt[t].exp_pc);
            chk({vt[t].name, "_acc"}, dut.acc_q, vt[t].exp_acc);
            chk({vt[t].name, "_leds"}, leds_now(), {13'h0, vt[t].exp_leds});
            chk({vt[t].name, "_m22"}, dut.mem_q[8'h22], vt[t].exp_m22);
            chk({vt[t].name, "_we_cycles"}, 16'(we_cnt), 16'(vt[t].exp_we));
            $display("vector %s: cycles=%0d acc=%h pc=%h leds=%b", vt[t].name, cyc, dut.acc_q, dut.pc_q,
                     {led1, led2, led3});
        end

        // ---------------- random programs vs reference model ----------------
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 256; i++) begin
                rop    = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                img[i] = {rop, 12'($urandom)};
            end
            start_run();
            for (int k = 0; k < 60; k++) begin
                model_step();
                repeat (3) @(posedge clk_i);
                #1;
                chk("rnd_pc", dut.pc_q, m_pc);
                chk("rnd_acc", dut.acc_q, m_acc);
                chk("rnd_leds", leds_now(), {13'h0, ~m_zf, ~m_sf, ~m_cf});
                chk("rnd_halt", 16'(dut.halted), 16'(m_halt));
            end
            diffs = 0;
            for (int i = 0; i < 256; i++) if (dut.mem_q[i] !== m_mem[i]) diffs++;
            chk("rnd_mem_words_differing", 16'(diffs), 16'h0);
            $display("random program %0d: pc=%h acc=%h halted=%0d", p, m_pc, m_acc, m_halt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
